// File: rtl/memory_stream_reader.sv
// Read-side initiator for a dual-port memory: turns a (start, length) command
// into sequential reads and a valid/ready word stream with a last-word marker.
module memory_stream_reader #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_address,
    input  logic [ADDRESS_WIDTH:0]   cmd_length,
    output logic                     mem_enable_read,
    output logic [ADDRESS_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ONE_ADDR = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0]   ONE_REM  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0]   ZERO_REM = {(ADDRESS_WIDTH+1){1'b0}};

    state_t                   state_r;
    logic [ADDRESS_WIDTH-1:0] pointer_r;
    logic [ADDRESS_WIDTH:0]   remaining_r;
    logic                     inflight_r;
    logic [1:0]               count_r;
    logic [DATA_WIDTH-1:0]    head_data_r;
    logic [DATA_WIDTH-1:0]    tail_data_r;
    logic                     head_last_r;
    logic                     tail_last_r;

    logic                     pop_s;
    logic                     push_s;
    logic                     push_last_s;
    logic                     issue_s;
    logic [2:0]               occupancy_s;

    // Handshake, capture and read-issue decisions for the current cycle.
    always_comb begin
        pop_s       = (count_r != 2'd0) && out_ready;
        push_s      = inflight_r;
        // A word captured while nothing remains to be issued is the command's final word.
        push_last_s = (remaining_r == ZERO_REM);
        occupancy_s = {1'b0, count_r} + {2'b00, inflight_r};
        if ((state_r == ST_RUN) && (remaining_r != ZERO_REM)) begin
            if (occupancy_s < (3'd2 + {2'b00, pop_s})) begin
                issue_s = 1'b1;
            end else begin
                issue_s = 1'b0;
            end
        end else begin
            issue_s = 1'b0;
        end
    end

    assign cmd_ready        = (state_r == ST_IDLE);
    assign busy             = (state_r != ST_IDLE);
    assign mem_enable_read  = issue_s;
    assign mem_read_address = pointer_r;
    assign out_valid        = (count_r != 2'd0);
    assign out_data         = head_data_r;
    assign out_last         = head_last_r;

    // Command sequencing: address pointer, remaining count and state.
    always_ff @(posedge clka) begin
        if (!rsta) begin
            state_r     <= ST_IDLE;
            pointer_r   <= {ADDRESS_WIDTH{1'b0}};
            remaining_r <= ZERO_REM;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        pointer_r   <= cmd_address;
                        remaining_r <= cmd_length;
                        if (cmd_length != ZERO_REM) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        pointer_r   <= pointer_r + ONE_ADDR;
                        remaining_r <= remaining_r - ONE_REM;
                        if (remaining_r == ONE_REM) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!inflight_r && ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s))) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-latency tracking and the 2-entry output buffer; head is always out_data.
    always_ff @(posedge clka) begin
        if (!rsta) begin
            inflight_r  <= 1'b0;
            count_r     <= 2'd0;
            head_data_r <= {DATA_WIDTH{1'b0}};
            tail_data_r <= {DATA_WIDTH{1'b0}};
            head_last_r <= 1'b0;
            tail_last_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_data_r <= mem_read_data;
                        head_last_r <= push_last_s;
                    end else begin
                        tail_data_r <= mem_read_data;
                        tail_last_r <= push_last_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_data_r <= tail_data_r;
                    head_last_r <= tail_last_r;
                    count_r     <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_data_r <= mem_read_data;
                        head_last_r <= push_last_s;
                    end else begin
                        head_data_r <= tail_data_r;
                        head_last_r <= tail_last_r;
                        tail_data_r <= mem_read_data;
                        tail_last_r <= push_last_s;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Bench for memory_stream_reader: a behavioural memory plus a reference model
// that lists the expected read addresses and stream words for each command.
module tb_memory_stream_reader;

    logic        clka = 1'b0;
    logic        rsta;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_address;
    logic [10:0] cmd_length;
    logic        mem_enable_read;
    logic [9:0]  mem_read_address;
    logic [31:0] mem_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    memory_stream_reader #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clka             (clka),
        .rsta             (rsta),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_address      (cmd_address),
        .cmd_length       (cmd_length),
        .mem_enable_read  (mem_enable_read),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .busy             (busy)
    );

    always #5 clka = ~clka;

    logic [31:0] mem [1024];

    // One-cycle read latency memory.
    always @(posedge clka) begin
        if (mem_enable_read === 1'b1) mem_read_data <= mem[mem_read_address];
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [9:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    logic        exp_last [$];
    int          issued = 0;
    int          delivered = 0;
    int          tick_idx = 0;
    int          first_valid_tick = -1;
    int          last_hs_tick = -1;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;
    int          pat [6] = '{1, 0, 0, 1, 0, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe one cycle at the falling edge, then advance past the next rising edge.
    task automatic tick();
        logic pop;
        @(negedge clka);
        tick_idx++;
        pop = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (mem_enable_read === 1'b1) begin
            if (exp_addr.size() == 0) chk("spurious_read", 64'd1, 64'd0);
            else chk("read_addr", 64'(mem_read_address), 64'(exp_addr.pop_front()));
            chk("issue_room", 64'((issued - delivered - (pop ? 1 : 0)) < 2), 64'd1);
            issued++;
        end
        if (stall_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(prev_data));
            chk("stall_last", 64'(out_last), 64'(prev_last));
        end
        if (out_valid === 1'b1 && first_valid_tick < 0) first_valid_tick = tick_idx;
        if (pop) begin
            if (exp_data.size() == 0) chk("spurious_word", 64'd1, 64'd0);
            else begin
                chk("out_data", 64'(out_data), 64'(exp_data.pop_front()));
                chk("out_last", 64'(out_last), 64'(exp_last.pop_front()));
            end
            delivered++;
            last_hs_tick = tick_idx;
        end
        stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_data  = out_data;
        prev_last  = out_last;
        @(posedge clka);
        #1;
    endtask

    task automatic expect_cmd(input logic [9:0] addr, input int len);
        for (int i = 0; i < len; i++) begin
            int a;
            a = (int'(addr) + i) % 1024;
            exp_addr.push_back(10'(a));
            exp_data.push_back(mem[a]);
            exp_last.push_back(i == len - 1);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: fixed 1,0,0,1,0,1 pattern.
    task automatic run_cmd(input logic [9:0] addr, input int len, input int mode);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        expect_cmd(addr, len);
        cmd_valid   = 1'b1;
        cmd_address = addr;
        cmd_length  = 11'(len);
        out_ready   = 1'b1;
        tick();
        tick_idx = 0;
        first_valid_tick = -1;
        last_hs_tick = -1;
        while (exp_data.size() != 0 && tick_idx < 64 + 4 * len) begin
            // Junk command inputs for a few cycles must be ignored while busy.
            cmd_valid   = (tick_idx < 3);
            cmd_address = 10'($urandom());
            cmd_length  = 11'($urandom());
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'(pat[tick_idx % 6]);
                default: out_ready = 1'b1;
            endcase
            tick();
        end
        cmd_valid = 1'b0;
        chk("words_left", 64'(exp_data.size()), 64'd0);
        chk("reads_left", 64'(exp_addr.size()), 64'd0);
        chk("first_valid_latency", 64'(first_valid_tick), 64'd3);
        if (mode == 0) chk("last_handshake_tick", 64'(last_hs_tick), 64'(len + 2));
        chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] r;
            r = $urandom();
            mem[i] = {r[31:10], 10'(i)};
        end
        rsta = 1'b0;
        cmd_valid = 1'b0;
        cmd_address = 10'd0;
        cmd_length = 11'd0;
        out_ready = 1'b0;
        tick();
        tick();
        rsta = 1'b1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_enable", 64'(mem_enable_read), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);

        run_cmd(10'h010, 4, 0);
        run_cmd(10'h010, 4, 2);

        // Zero-length command is consumed without reads or output.
        begin
            int i0, d0;
            i0 = issued;
            d0 = delivered;
            cmd_valid = 1'b1;
            cmd_address = 10'($urandom());
            cmd_length = 11'd0;
            out_ready = 1'b1;
            tick();
            cmd_valid = 1'b0;
            chk("len0_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("len0_busy", 64'(busy), 64'd0);
            repeat (4) tick();
            chk("len0_no_reads", 64'(issued - i0), 64'd0);
            chk("len0_no_words", 64'(delivered - d0), 64'd0);
            chk("len0_busy_later", 64'(busy), 64'd0);
        end

        run_cmd(10'h3FE, 4, 0);

        // Reset in the middle of a stalled 8-word command.
        begin
            int d0;
            int guard;
            d0 = delivered;
            guard = 0;
            expect_cmd(10'($urandom()), 8);
            cmd_valid = 1'b1;
            cmd_address = exp_addr[0];
            cmd_length = 11'd8;
            out_ready = 1'b1;
            tick();
            cmd_valid = 1'b0;
            while (delivered - d0 < 2 && guard < 20) begin
                out_ready = 1'b1;
                tick();
                guard++;
            end
            out_ready = 1'b0;
            repeat (6) tick();
            chk("pre_reset_words", 64'(delivered - d0), 64'd2);
            rsta = 1'b0;
            tick();
            rsta = 1'b1;
            exp_addr.delete();
            exp_data.delete();
            exp_last.delete();
            issued = 0;
            delivered = 0;
            stall_prev = 1'b0;
            chk("midrst_out_valid", 64'(out_valid), 64'd0);
            chk("midrst_busy", 64'(busy), 64'd0);
            chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("midrst_enable", 64'(mem_enable_read), 64'd0);
            chk("midrst_out_data", 64'(out_data), 64'd0);
            run_cmd(10'h020, 2, 0);
        end

        // Full-memory read that must wrap, followed immediately by a single word.
        run_cmd(10'($urandom_range(1, 1023)), 1024, 0);
        run_cmd(10'($urandom()), 1, 0);

        for (int k = 0; k < 8; k++) begin
            run_cmd(10'($urandom_range(990, 1023)), $urandom_range(1, 40), 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
